// File: rtl/axi_bw_resp_scheduler.sv
// axi_bw_resp_scheduler
// Target-port B channel scheduler: round-robin merge of the initiator-side B
// responses into one registered output, outstanding-write tracking, and
// injection of a single DECERR response once all outstanding responses drained.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | normal arbitration, waiting for an error request
// DRAIN  | error accepted, arbitration continues until counter==0 and reg empty
// ISSUE  | arbitration blocked, DECERR loaded into output reg when it can load
// RESP   | arbitration blocked, waiting for the DECERR handshake downstream
module axi_bw_resp_scheduler #(
    parameter int N_INIT_PORT = 4,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + 2,
    parameter int AXI_USER_W  = 6,
    parameter int CNT_W       = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
    input  logic [N_INIT_PORT*2-1:0]          bresp_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
    input  logic [N_INIT_PORT-1:0]            bvalid_i,
    output logic [N_INIT_PORT-1:0]            bready_o,
    output logic [AXI_ID_IN-1:0]              bid_o,
    output logic [1:0]                        bresp_o,
    output logic [AXI_USER_W-1:0]             buser_o,
    output logic                              bvalid_o,
    input  logic                              bready_i,
    input  logic                              incr_req_i,
    output logic                              full_counter_o,
    output logic                              outstanding_trans_o,
    input  logic                              error_req_i,
    input  logic [AXI_ID_IN-1:0]              error_id_i,
    input  logic [AXI_USER_W-1:0]             error_user_i,
    output logic                              error_gnt_o
);

    localparam int PTR_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_ISSUE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   gnt_found;
    logic                   ld;
    logic                   arb_en;
    logic                   src_hs;
    logic                   load_err;
    logic                   out_err_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   cnt_dec;
    logic [AXI_ID_IN-1:0]   err_id_q;
    logic [AXI_USER_W-1:0]  err_user_q;
    logic [AXI_ID_IN-1:0]   sel_id;
    logic [1:0]             sel_resp;
    logic [AXI_USER_W-1:0]  sel_user;

    assign ld     = !bvalid_o || bready_i;
    assign arb_en = (state_q == S_IDLE) || (state_q == S_DRAIN);
    assign src_hs = arb_en && ld && gnt_found;

    // Round-robin search: first valid source at or after the pointer, wrapping.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_INIT_PORT; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_INIT_PORT) idx = idx - N_INIT_PORT;
            if (!gnt_found && bvalid_i[PTR_W'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    // Payload of the granted source; routing bits above AXI_ID_IN are dropped.
    always_comb begin
        sel_id   = bid_i[int'(gnt_idx)*AXI_ID_OUT +: AXI_ID_IN];
        sel_resp = bresp_i[int'(gnt_idx)*2 +: 2];
        sel_user = buser_i[int'(gnt_idx)*AXI_USER_W +: AXI_USER_W];
    end

    // Ready goes only to the granted source, and only when the output reg can take it.
    always_comb begin
        bready_o = '0;
        if (src_hs) bready_o[gnt_idx] = 1'b1;
    end

    // Pointer moves to the source after the one just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (src_hs) begin
            ptr_q <= (gnt_idx == PTR_W'(N_INIT_PORT - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Output register: DECERR injection, arbitrated response, or drain to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_o  <= 1'b0;
            bid_o     <= '0;
            bresp_o   <= '0;
            buser_o   <= '0;
            out_err_q <= 1'b0;
        end else if (ld) begin
            if (load_err) begin
                bvalid_o  <= 1'b1;
                bid_o     <= err_id_q;
                bresp_o   <= 2'b11;
                buser_o   <= err_user_q;
                out_err_q <= 1'b1;
            end else if (src_hs) begin
                bvalid_o  <= 1'b1;
                bid_o     <= sel_id;
                bresp_o   <= sel_resp;
                buser_o   <= sel_user;
                out_err_q <= 1'b0;
            end else begin
                bvalid_o  <= 1'b0;
                out_err_q <= 1'b0;
            end
        end
    end

    // Injected DECERRs were never counted, so only arbitrated handshakes decrement.
    assign cnt_dec = bvalid_o && bready_i && !out_err_q;

    // Outstanding counter, saturating at both ends; simultaneous incr/decr cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({incr_req_i, cnt_dec})
                2'b10:   if (!(&cnt_q))      cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   if (cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign full_counter_o      = &cnt_q;
    assign outstanding_trans_o = (cnt_q != '0);

    // Error id/user captured when the request is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_id_q   <= '0;
            err_user_q <= '0;
        end else if (state_q == S_IDLE && error_req_i) begin
            err_id_q   <= error_id_i;
            err_user_q <= error_user_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; ISSUE waits for a free output reg before granting the error.
    always_comb begin
        state_d     = state_q;
        load_err    = 1'b0;
        error_gnt_o = 1'b0;
        case (state_q)
            S_IDLE:  if (error_req_i) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == '0 && !bvalid_o) state_d = S_ISSUE;
            S_ISSUE: begin
                if (ld) begin
                    load_err    = 1'b1;
                    error_gnt_o = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP:  if (bvalid_o && bready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_bw_resp_scheduler.sv
// Directed bench for axi_bw_resp_scheduler: a scoreboard queue of expected
// output beats is filled as sources are granted and drained by a monitor.
module tb_axi_bw_resp_scheduler;

    localparam int N  = 4;
    localparam int ID = 16;
    localparam int IO = ID + 2;
    localparam int UW = 6;
    localparam int CW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*IO-1:0]   bid_i;
    logic [N*2-1:0]    bresp_i;
    logic [N*UW-1:0]   buser_i;
    logic [N-1:0]      bvalid_i;
    logic [N-1:0]      bready_o;
    logic [ID-1:0]     bid_o;
    logic [1:0]        bresp_o;
    logic [UW-1:0]     buser_o;
    logic              bvalid_o;
    logic              bready_i;
    logic              incr_req_i;
    logic              full_counter_o;
    logic              outstanding_trans_o;
    logic              error_req_i;
    logic [ID-1:0]     error_id_i;
    logic [UW-1:0]     error_user_i;
    logic              error_gnt_o;

    int checks = 0;
    int errors = 0;

    logic [ID-1:0]     src_id   [N];
    logic [1:0]        src_resp [N];
    logic [UW-1:0]     src_user [N];
    logic [ID+2+UW-1:0] exp_q[$];

    axi_bw_resp_scheduler #(
        .N_INIT_PORT(N), .AXI_ID_IN(ID), .AXI_ID_OUT(IO), .AXI_USER_W(UW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i), .bvalid_i(bvalid_i),
        .bready_o(bready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o), .bvalid_o(bvalid_o),
        .bready_i(bready_i),
        .incr_req_i(incr_req_i), .full_counter_o(full_counter_o),
        .outstanding_trans_o(outstanding_trans_o),
        .error_req_i(error_req_i), .error_id_i(error_id_i), .error_user_i(error_user_i),
        .error_gnt_o(error_gnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int g, input logic [ID-1:0] id, input logic [1:0] rs,
                           input logic [UW-1:0] us);
        src_id[g]   = id;
        src_resp[g] = rs;
        src_user[g] = us;
        bid_i[g*IO +: IO]   = {2'b10, id};
        bresp_i[g*2 +: 2]   = rs;
        buser_i[g*UW +: UW] = us;
    endtask

    task automatic push_src(input int g);
        exp_q.push_back({src_id[g], src_resp[g], src_user[g]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Scoreboard: every downstream handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (!rst && bvalid_o === 1'b1 && bready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", {bid_o, bresp_o, buser_o});
            end else begin
                automatic logic [ID+2+UW-1:0] e = exp_q.pop_front();
                assert ({bid_o, bresp_o, buser_o} === e) else begin
                    errors++;
                    $error("FAIL sb_beat observed=%0h expected=%0h", {bid_o, bresp_o, buser_o}, e);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; bid_i = '0; bresp_i = '0; buser_i = '0; bvalid_i = '0;
        bready_i = 1'b1; incr_req_i = 1'b0; error_req_i = 1'b0;
        error_id_i = '0; error_user_i = '0;
        for (int g = 0; g < N; g++) set_src(g, '0, '0, '0);
        do_reset();

        // reset state
        #1;
        chk("rst_bvalid", bvalid_o, 0);
        chk("rst_bid", bid_o, 0);
        chk("rst_bresp", bresp_o, 0);
        chk("rst_buser", buser_o, 0);
        chk("rst_outstanding", outstanding_trans_o, 0);
        chk("rst_full", full_counter_o, 0);
        chk("rst_gnt", error_gnt_o, 0);
        chk("rst_bready", bready_o, 0);

        // 1: all sources valid, round-robin 0,1,2,3,0
        for (int g = 0; g < N; g++)
            set_src(g, ID'(16'h1000 + g), (g == 1) ? 2'b01 : (g == 3) ? 2'b10 : 2'b00, UW'(g + 3));
        bvalid_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", bready_o, 32'(1 << (k % 4)));
            chk("rr_bvalid_lat", bvalid_o, (k > 0) ? 1 : 0);
            push_src(k % 4);
            tick();
        end
        bvalid_i = '0;
        #1;
        chk("rr_idle_ready", bready_o, 0);
        chk("rr_last_valid", bvalid_o, 1);
        tick();
        chk("rr_drained", bvalid_o, 0);

        // 2: backpressure holds the output stable
        set_src(2, 16'h2222, 2'b00, 6'h11);
        bvalid_i = 4'b0100;
        bready_i = 1'b0;
        #1;
        chk("bp_first_grant", bready_o, 4'b0100);
        push_src(2);
        tick();
        set_src(2, 16'h2333, 2'b01, 6'h12);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_hold_valid", bvalid_o, 1);
            chk("bp_hold_id", bid_o, 16'h2222);
            chk("bp_hold_ready", bready_o, 0);
            tick();
        end
        bready_i = 1'b1;
        #1;
        chk("bp_release_grant", bready_o, 4'b0100);
        push_src(2);
        tick();
        bvalid_i = '0;
        #1;
        chk("bp_second_id", bid_o, 16'h2333);
        tick();
        chk("bp_drained", bvalid_o, 0);

        // 3: five writes, six responses with one simultaneous incr+decr
        incr_req_i = 1'b1;
        repeat (5) tick();
        incr_req_i = 1'b0;
        chk("cnt_outstanding_5", outstanding_trans_o, 1);
        for (int s = 0; s < 6; s++) begin
            set_src(1, ID'(16'h3000 + s), 2'b00, UW'(s));
            bvalid_i   = 4'b0010;
            incr_req_i = (s == 3);
            #1;
            chk("cnt_grant", bready_o, 4'b0010);
            chk("cnt_outstanding_mid", outstanding_trans_o, 1);
            push_src(1);
            tick();
        end
        bvalid_i   = '0;
        incr_req_i = 1'b0;
        #1;
        chk("cnt_outstanding_1", outstanding_trans_o, 1);
        tick();
        chk("cnt_outstanding_0", outstanding_trans_o, 0);
        chk("cnt_bvalid_0", bvalid_o, 0);

        // 4: DECERR after two outstanding responses drain
        incr_req_i = 1'b1;
        tick();
        tick();
        incr_req_i   = 1'b0;
        error_req_i  = 1'b1;
        error_id_i   = 16'h001A;
        error_user_i = 6'h2A;
        tick();
        set_src(3, 16'h4000, 2'b00, 6'h01);
        bvalid_i = 4'b1000;
        #1;
        chk("err_drain_grant0", bready_o, 4'b1000);
        chk("err_no_gnt0", error_gnt_o, 0);
        push_src(3);
        tick();
        set_src(3, 16'h4001, 2'b01, 6'h02);
        #1;
        chk("err_drain_grant1", bready_o, 4'b1000);
        chk("err_no_gnt1", error_gnt_o, 0);
        push_src(3);
        tick();
        bvalid_i = '0;
        #1;
        chk("err_no_gnt2", error_gnt_o, 0);
        tick();
        chk("err_no_gnt3", error_gnt_o, 0);
        n = 0;
        while (error_gnt_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("err_gnt_seen", error_gnt_o, 1);
        chk("err_gnt_latency", n, 1);
        exp_q.push_back({16'h001A, 2'b11, 6'h2A});
        error_req_i = 1'b0;
        incr_req_i  = 1'b1;
        set_src(0, 16'h5000, 2'b00, 6'h05);
        bvalid_i = 4'b0001;
        bready_i = 1'b0;
        #1;
        chk("err_issue_ready", bready_o, 0);
        tick();
        incr_req_i = 1'b0;
        #1;
        chk("err_resp_valid", bvalid_o, 1);
        chk("err_resp_bresp", bresp_o, 2'b11);
        chk("err_resp_bid", bid_o, 16'h001A);
        chk("err_resp_buser", buser_o, 6'h2A);
        chk("err_gnt_pulse", error_gnt_o, 0);
        chk("err_resp_ready", bready_o, 0);
        tick();
        bready_i = 1'b1;
        #1;
        chk("err_resp_ready_ld", bready_o, 0);
        tick();
        chk("err_no_decr", outstanding_trans_o, 1);
        chk("err_back_idle_valid", bvalid_o, 0);
        chk("err_back_idle_grant", bready_o, 4'b0001);
        push_src(0);
        tick();
        bvalid_i = '0;
        tick();
        chk("err_final_outstanding", outstanding_trans_o, 0);

        // 5: counter saturation at all-ones
        incr_req_i = 1'b1;
        repeat (1022) tick();
        chk("sat_not_full_1022", full_counter_o, 0);
        tick();
        chk("sat_full_1023", full_counter_o, 1);
        tick();
        incr_req_i = 1'b0;
        #1;
        chk("sat_full_held", full_counter_o, 1);
        set_src(2, 16'h6000, 2'b10, 6'h06);
        bvalid_i = 4'b0100;
        #1;
        chk("sat_grant", bready_o, 4'b0100);
        push_src(2);
        tick();
        bvalid_i = '0;
        tick();
        chk("sat_full_after_decr", full_counter_o, 0);
        chk("sat_outstanding_after_decr", outstanding_trans_o, 1);

        // 6: reset while a DECERR is waiting in RESP
        do_reset();
        set_src(1, 16'h7001, 2'b00, 6'h07);
        bvalid_i = 4'b0010;
        #1;
        chk("r6_grant1", bready_o, 4'b0010);
        push_src(1);
        tick();
        bvalid_i = '0;
        tick();
        error_req_i  = 1'b1;
        error_id_i   = 16'h00BB;
        error_user_i = 6'h3B;
        n = 0;
        while (error_gnt_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("r6_gnt_seen", error_gnt_o, 1);
        error_req_i = 1'b0;
        bready_i    = 1'b0;
        tick();
        chk("r6_resp_valid", bvalid_o, 1);
        incr_req_i = 1'b1;
        tick();
        incr_req_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("r6_bvalid", bvalid_o, 0);
        chk("r6_bresp", bresp_o, 0);
        chk("r6_outstanding", outstanding_trans_o, 0);
        chk("r6_gnt", error_gnt_o, 0);
        bready_i = 1'b1;
        set_src(0, 16'h7100, 2'b00, 6'h08);
        set_src(3, 16'h7103, 2'b00, 6'h09);
        bvalid_i = 4'b1001;
        #1;
        chk("r6_idle_ptr0_grant", bready_o, 4'b0001);
        push_src(0);
        tick();
        bvalid_i = '0;
        tick();
        chk("r6_final_valid", bvalid_o, 0);
        chk("sb_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
